dram_arbiter_nch: RTL and testbench



---
 rtl/dram_arb_pkg.sv | 32 +++
 rtl/dram_arbiter_nch_rr_pick.sv | 38 +++
 rtl/dram_arbiter_nch.sv | 161 ++++++++++++++++
 tb/tb_dram_arbiter_nch.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types, default widths and sizing helpers for the N-channel DRAM arbiter.
package dram_arb_pkg;

  localparam int unsigned DEF_AW = 21;
  localparam int unsigned DEF_DW = 16;

  // Channel index field of the read tag is sized for the largest supported NCH (8).
  localparam int unsigned CH_IDX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] ch;
  } rd_tag_t;

  localparam int unsigned TAG_W = 1 + CH_IDX_W;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Pointer width, never narrower than one bit so NCH=1 still has a legal vector.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : log2_ceil(n);
  endfunction

endpackage

// File: rtl/dram_arbiter_nch_rr_pick.sv
// Rotate-priority encoder: first requester above 'last', wrapping modulo NCH.
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned PW  = ptr_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  last,
  output logic [NCH-1:0] grant_c,
  output logic [PW-1:0]  idx_c,
  output logic           any_c
);

  logic [NCH-1:0] rot;
  int unsigned    sum;

  // Rotate so bit 0 is channel last+1, take the lowest set bit, map back to a channel.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    sum     = 0;
    rot     = NCH'({req, req} >> (32'(last) + 32'd1));
    for (int unsigned j = 0; j < NCH; j++) begin
      if (!any_c && rot[j]) begin
        any_c = 1'b1;
        sum   = 32'(last) + j + 32'd1;
        if (sum >= NCH) sum = sum - NCH;
        idx_c = PW'(sum);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      grant_c[i] = any_c && (idx_c == PW'(i));
    end
  end

endmodule

// File: rtl/dram_arbiter_nch.sv
// N-channel round-robin arbiter in front of the single DRAM controller port.
// One grant per DRAM cycle (dram_cbeg), read data steered back by a one-deep tag.
// Optional build macro DRAM_ARB_CH0_PRIO_EN: channel 0 (video) pre-empts the
// round-robin whenever it requests and does not move the pointer.
module dram_arbiter_nch
  import dram_arb_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = DEF_AW,
  parameter int unsigned DW  = DEF_DW
) (
  input  logic                  fclk,
  input  logic                  rst,
  input  logic                  dram_cbeg,
  input  logic                  dram_rrdy,
  input  logic [DW-1:0]         dram_rddata,
  output logic                  dram_req,
  output logic                  dram_rnw,
  output logic [AW-1:0]         dram_addr,
  output logic [DW-1:0]         dram_wrdata,
  output logic [DW/8-1:0]       dram_bsel,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_rnw,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH*DW-1:0]     ch_wrdata,
  input  logic [NCH*DW/8-1:0]   ch_bsel,
  output logic [NCH-1:0]        ch_ack,
  output logic [NCH-1:0]        ch_rdstb,
  output logic [DW-1:0]         rddata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = ptr_w(NCH);

  logic [PW-1:0]  last_grant;
  logic [NCH-1:0] rr_req;
  logic [NCH-1:0] rr_grant;
  logic [PW-1:0]  rr_idx;
  logic           rr_any;

  logic           win_any;
  logic [PW-1:0]  win_idx;
  logic [NCH-1:0] win_onehot;
  logic           win_upd_ptr;
  logic           win_rnw;
  logic [AW-1:0]  win_addr;
  logic [DW-1:0]  win_wrdata;
  logic [BW-1:0]  win_bsel;

  rd_tag_t        tag;
  logic [NCH-1:0] tag_onehot;

`ifdef DRAM_ARB_CH0_PRIO_EN
  // Channel 0 is handled by the override, the rotation only sees channels 1..NCH-1.
  assign rr_req = ch_req & ~NCH'(1);
`else
  assign rr_req = ch_req;
`endif

  rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_rr_pick (
    .req     (rr_req),
    .last    (last_grant),
    .grant_c (rr_grant),
    .idx_c   (rr_idx),
    .any_c   (rr_any)
  );

  // Winner selection (with optional ch0 override) and payload mux.
  always_comb begin
    win_any     = rr_any;
    win_idx     = rr_idx;
    win_onehot  = rr_grant;
    win_upd_ptr = rr_any;
`ifdef DRAM_ARB_CH0_PRIO_EN
    if (ch_req[0]) begin
      win_any     = 1'b1;
      win_idx     = '0;
      win_onehot  = NCH'(1);
      win_upd_ptr = 1'b0;
    end
`endif
    win_rnw    = 1'b1;
    win_addr   = '0;
    win_wrdata = '0;
    win_bsel   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (win_idx == PW'(i)) begin
        win_rnw    = ch_rnw[i];
        win_addr   = ch_addr[i*AW +: AW];
        win_wrdata = ch_wrdata[i*DW +: DW];
        win_bsel   = ch_bsel[i*BW +: BW];
      end
    end
  end

  // Tag channel decoded to a strobe vector.
  always_comb begin
    tag_onehot = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      tag_onehot[i] = (tag.ch == CH_IDX_W'(i));
    end
  end

  // Slot issue: latch the winner onto the DRAM port at cbeg and pulse its ack.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      dram_req    <= 1'b0;
      dram_rnw    <= 1'b1;
      dram_addr   <= '0;
      dram_wrdata <= '0;
      dram_bsel   <= '0;
      ch_ack      <= '0;
    end else begin
      ch_ack <= '0;
      if (dram_cbeg) begin
        if (win_any) begin
          dram_req    <= 1'b1;
          dram_rnw    <= win_rnw;
          dram_addr   <= win_addr;
          dram_wrdata <= win_wrdata;
          dram_bsel   <= win_bsel;
          ch_ack      <= win_onehot;
        end else begin
          dram_req <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer follows the last rotating winner.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      last_grant <= '0;
    end else if (dram_cbeg && win_upd_ptr) begin
      last_grant <= win_idx;
    end
  end

  // Read return: consume the old tag on rrdy, then load a new one if this slot is a read.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      tag      <= '0;
      ch_rdstb <= '0;
      rddata   <= '0;
    end else begin
      ch_rdstb <= '0;
      if (dram_rrdy && tag.valid) begin
        rddata    <= dram_rddata;
        ch_rdstb  <= tag_onehot;
        tag.valid <= 1'b0;
      end
      if (dram_cbeg && win_any && win_rnw) begin
        tag <= '{valid: 1'b1, ch: CH_IDX_W'(win_idx)};
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter_nch.sv
// Self-checking bench for dram_arbiter_nch (NCH=4) against a slot-level reference model.
module tb_dram_arbiter_nch;

  localparam int NCH = 4;
  localparam int AW  = 21;
  localparam int DW  = 16;
  localparam int BW  = DW / 8;

  logic                fclk = 1'b0;
  logic                rst;
  logic                dram_cbeg;
  logic                dram_rrdy;
  logic [DW-1:0]       dram_rddata;
  logic                dram_req;
  logic                dram_rnw;
  logic [AW-1:0]       dram_addr;
  logic [DW-1:0]       dram_wrdata;
  logic [BW-1:0]       dram_bsel;
  logic [NCH-1:0]      ch_req;
  logic [NCH-1:0]      ch_rnw;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*DW-1:0]   ch_wrdata;
  logic [NCH*BW-1:0]   ch_bsel;
  logic [NCH-1:0]      ch_ack;
  logic [NCH-1:0]      ch_rdstb;
  logic [DW-1:0]       rddata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_last;
  int            m_tag;
  logic [DW-1:0] m_rddata;
  logic          m_req;
  logic          m_rnw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr;
  logic [BW-1:0] m_bsel;

  dram_arbiter_nch #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .fclk        (fclk),
    .rst         (rst),
    .dram_cbeg   (dram_cbeg),
    .dram_rrdy   (dram_rrdy),
    .dram_rddata (dram_rddata),
    .dram_req    (dram_req),
    .dram_rnw    (dram_rnw),
    .dram_addr   (dram_addr),
    .dram_wrdata (dram_wrdata),
    .dram_bsel   (dram_bsel),
    .ch_req      (ch_req),
    .ch_rnw      (ch_rnw),
    .ch_addr     (ch_addr),
    .ch_wrdata   (ch_wrdata),
    .ch_bsel     (ch_bsel),
    .ch_ack      (ch_ack),
    .ch_rdstb    (ch_rdstb),
    .rddata      (rddata)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rules: search upward from last+1 modulo NCH.
  function automatic int pick(input logic [NCH-1:0] req, input int lst);
    int c;
`ifdef DRAM_ARB_CH0_PRIO_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= NCH; k++) begin
      c = (lst + k) % NCH;
`ifdef DRAM_ARB_CH0_PRIO_EN
      if (c == 0) continue;
`endif
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last   = 0;
    m_tag    = -1;
    m_rddata = '0;
    m_req    = 1'b0;
    m_rnw    = 1'b1;
    m_addr   = '0;
    m_wr     = '0;
    m_bsel   = '0;
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [NCH-1:0] ea, input logic [NCH-1:0] es);
    chk({tag, "_ack"},    32'(ch_ack),      32'(ea));
    chk({tag, "_rdstb"},  32'(ch_rdstb),    32'(es));
    chk({tag, "_rddata"}, 32'(rddata),      32'(m_rddata));
    chk({tag, "_req"},    32'(dram_req),    32'(m_req));
    chk({tag, "_rnw"},    32'(dram_rnw),    32'(m_rnw));
    chk({tag, "_addr"},   32'(dram_addr),   32'(m_addr));
    chk({tag, "_wrdata"}, 32'(dram_wrdata), 32'(m_wr));
    chk({tag, "_bsel"},   32'(dram_bsel),   32'(m_bsel));
  endtask

  task automatic set_ch(input int c, input logic rnw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] b);
    ch_req[c]             = 1'b1;
    ch_rnw[c]             = rnw;
    ch_addr[c*AW +: AW]   = a;
    ch_wrdata[c*DW +: DW] = d;
    ch_bsel[c*BW +: BW]   = b;
  endtask

  // One DRAM cycle start, optionally with a coincident rrdy.
  task automatic slot(input string tag, input logic rr, input logic [DW-1:0] rd, output int w);
    logic [NCH-1:0] ea;
    logic [NCH-1:0] es;
    ea = '0;
    es = '0;
    w  = pick(ch_req, m_last);
    if (rr && m_tag >= 0) begin
      es[m_tag] = 1'b1;
      m_rddata  = rd;
      m_tag     = -1;
    end
    if (w >= 0) begin
      ea[w]  = 1'b1;
      m_req  = 1'b1;
      m_rnw  = ch_rnw[w];
      m_addr = ch_addr[w*AW +: AW];
      m_wr   = ch_wrdata[w*DW +: DW];
      m_bsel = ch_bsel[w*BW +: BW];
      if (ch_rnw[w]) m_tag = w;
`ifdef DRAM_ARB_CH0_PRIO_EN
      if (w != 0) m_last = w;
`else
      m_last = w;
`endif
    end else begin
      m_req = 1'b0;
    end
    dram_cbeg   = 1'b1;
    dram_rrdy   = rr;
    dram_rddata = rd;
    tick();
    dram_cbeg = 1'b0;
    dram_rrdy = 1'b0;
    check_outputs(tag, ea, es);
  endtask

  task automatic rrdy(input string tag, input logic [DW-1:0] rd);
    logic [NCH-1:0] es;
    es = '0;
    if (m_tag >= 0) begin
      es[m_tag] = 1'b1;
      m_rddata  = rd;
      m_tag     = -1;
    end
    dram_rrdy   = 1'b1;
    dram_rddata = rd;
    tick();
    dram_rrdy = 1'b0;
    check_outputs(tag, '0, es);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outputs(tag, '0, '0);
    end
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic apply_reset();
    ch_req = '0;
    rst    = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async", '0, '0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    rst         = 1'b1;
    dram_cbeg   = 1'b0;
    dram_rrdy   = 1'b0;
    dram_rddata = '0;
    ch_req      = '0;
    ch_rnw      = '0;
    ch_addr     = '0;
    ch_wrdata   = '0;
    ch_bsel     = '0;
    model_reset();
    #2;
    check_outputs("reset", '0, '0);
    tick();
    tick();
    check_outputs("reset_hold", '0, '0);
    rst = 1'b0;

    // Single write requester on ch2
    set_ch(2, 1'b0, 21'h1ABCD, 16'h55AA, 2'b11);
    slot("single", 1'b0, 16'h0, w);
    chk("single_ack_const", 32'(ch_ack), 32'h4);
    chk("single_addr_const", 32'(dram_addr), 32'h1ABCD);
    ch_req[2] = 1'b0;
    idle("single_idle", 2);

    // All four requesting continuously from a fresh reset
    apply_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, AW'(32'h100 + c), DW'(32'hA000 + c), 2'b01);
    for (int i = 0; i < 8; i++) begin
      slot("rr_all", 1'b0, 16'h0, w);
`ifndef DRAM_ARB_CH0_PRIO_EN
      chk("rr_seq", 32'(ch_ack), 32'(1 << ((i + 1) % NCH)));
`endif
    end
    ch_req = '0;
    idle("rr_idle", 1);

    // Read on ch2, data returns three cycles after grant, then a spurious rrdy
    set_ch(2, 1'b1, 21'h00123, 16'h0, 2'b00);
    slot("rd2", 1'b0, 16'h0, w);
    ch_req[2] = 1'b0;
    idle("rd2_wait", 2);
    rrdy("rd2_data", 16'hBEEF);
    chk("rd2_stb_const", 32'(ch_rdstb), 32'h4);
    chk("rd2_data_const", 32'(rddata), 32'hBEEF);
    rrdy("spurious", 16'h1111);
    chk("spurious_data_const", 32'(rddata), 32'hBEEF);

    // rrdy coincident with the cbeg that grants a ch1 read
    set_ch(2, 1'b1, 21'h00200, 16'h0, 2'b00);
    slot("coinc_a", 1'b0, 16'h0, w);
    ch_req[2] = 1'b0;
    idle("coinc_gap", 1);
    set_ch(1, 1'b1, 21'h00300, 16'h0, 2'b00);
    slot("coinc_b", 1'b1, 16'hA5A5, w);
    chk("coinc_stb_const", 32'(ch_rdstb), 32'h4);
    chk("coinc_ack_const", 32'(ch_ack), 32'h2);
    ch_req[1] = 1'b0;
    idle("coinc_gap2", 1);
    rrdy("coinc_late", 16'hC3C3);
    chk("coinc_late_stb_const", 32'(ch_rdstb), 32'h2);

    // ch0 and ch3 contending every slot, then ch0 drops
    set_ch(0, 1'b0, 21'h0AAAA, 16'h0F0F, 2'b10);
    set_ch(3, 1'b0, 21'h13333, 16'hF0F0, 2'b01);
    for (int i = 0; i < 4; i++) begin
      slot("ch0_ch3", 1'b0, 16'h0, w);
`ifdef DRAM_ARB_CH0_PRIO_EN
      chk("prio_ch0_const", 32'(ch_ack), 32'h1);
`endif
    end
    ch_req[0] = 1'b0;
    slot("ch3_after", 1'b0, 16'h0, w);
    chk("ch3_after_const", 32'(ch_ack), 32'h8);
    ch_req = '0;
    idle("prio_idle", 1);

    // Reset between a read grant and its data
    set_ch(1, 1'b1, 21'h04444, 16'h0, 2'b00);
    slot("pre_rst", 1'b0, 16'h0, w);
    ch_req[1] = 1'b0;
    apply_reset();
    rrdy("post_rst_rrdy", 16'h7777);
    chk("post_rst_stb_const", 32'(ch_rdstb), 32'h0);
    idle("no_cbeg", 3);

    // Randomised traffic: requesters hold until acked, random rrdy placement
    for (int s = 0; s < 300; s++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!ch_req[c] && $urandom_range(1, 0) == 1) begin
          set_ch(c, 1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom));
        end
      end
      slot("rnd_slot", ($urandom_range(3, 0) == 0), DW'($urandom), w);
      if (w >= 0) ch_req[w] = 1'b0;
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
        if ($urandom_range(2, 0) == 0) rrdy("rnd_rrdy", DW'($urandom));
        else idle("rnd_idle", 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
